// File: rtl/capture_pkg.sv
// Shared capture-path definitions: controller states and default queue geometry
// used by the capture writer, command config and RAMqueue blocks.
package capture_pkg;

    localparam int DEF_ENTRIES = 384;
    localparam int DEF_LOG2    = 9;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } cap_state_t;

endpackage

// File: rtl/wrap_cnt.sv
// Modulo-ENTRIES incrementing address counter with enable and synchronous clear.
// nxt exposes the post-increment value so callers can capture it on the same edge.
module wrap_cnt #(
    parameter int ENTRIES = 384,
    parameter int LOG2    = 9
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clr,
    input  logic            en,
    output logic [LOG2-1:0] q,
    output logic [LOG2-1:0] nxt
);

    always_comb begin
        nxt = q;
        if (en) nxt = (q == LOG2'(ENTRIES - 1)) ? '0 : q + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)      q <= '0;
        else if (clr) q <= '0;
        else          q <= nxt;
    end

endmodule

// File: rtl/capture_wrt.sv
// Capture controller: circular sample writes into the RAMqueue, arming once enough
// pre-trigger history exists, then exactly trig_pos post-trigger samples before DONE.
module capture_wrt
    import capture_pkg::*;
#(
    parameter int ENTRIES = DEF_ENTRIES,
    parameter int LOG2    = DEF_LOG2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            abort,
    input  logic            wrt_smpl,
    input  logic            triggered,
    input  logic [LOG2-1:0] trig_pos,
    output logic            we,
    output logic [LOG2-1:0] waddr,
    output logic            armed,
    output logic            capturing,
    output logic            set_capture_done,
    output logic [LOG2-1:0] ram_addr
);

    localparam logic [LOG2:0] FULL = (LOG2+1)'(ENTRIES);

    cap_state_t      state, state_nxt;
    logic [LOG2:0]   smpl_cnt, smpl_nxt;
    logic [LOG2-1:0] trig_cnt, trig_cnt_nxt;
    logic [LOG2-1:0] tp, waddr_nxt;
    logic            trig_seen, eff_trig, run, hit, go, done, arm_nxt;

    // A request past the end of the queue still leaves one pre-trigger sample.
    assign tp = ({1'b0, trig_pos} >= FULL) ? LOG2'(ENTRIES - 1) : trig_pos;

    assign run          = (state == RUN);
    assign eff_trig     = trig_seen | (triggered & armed);
    assign hit          = eff_trig && (trig_cnt == tp);
    assign we           = run & wrt_smpl & ~hit;
    assign trig_cnt_nxt = trig_cnt + LOG2'(we & eff_trig);
    assign smpl_nxt     = (we && smpl_cnt != FULL) ? smpl_cnt + 1'b1 : smpl_cnt;
    assign arm_nxt      = (smpl_nxt + {1'b0, tp}) >= FULL;
    assign capturing    = run;

    always_comb begin
        state_nxt = state;
        go        = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: if (!abort && start) go = 1'b1;
            RUN: begin
                if (abort) begin
                    state_nxt = IDLE;
                end else if (eff_trig && trig_cnt_nxt == tp) begin
                    state_nxt = DONE;
                    done      = 1'b1;
                end
            end
            DONE: begin
                if (abort)      state_nxt = IDLE;
                else if (start) go = 1'b1;
            end
            default: state_nxt = IDLE;
        endcase
        if (go) state_nxt = RUN;
    end

    wrap_cnt #(.ENTRIES(ENTRIES), .LOG2(LOG2)) u_waddr (
        .clk (clk),
        .rst (rst),
        .clr (go),
        .en  (we),
        .q   (waddr),
        .nxt (waddr_nxt)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state            <= IDLE;
            smpl_cnt         <= '0;
            trig_cnt         <= '0;
            trig_seen        <= 1'b0;
            armed            <= 1'b0;
            set_capture_done <= 1'b0;
            ram_addr         <= '0;
        end else begin
            state            <= state_nxt;
            set_capture_done <= done;
            if (go) begin
                smpl_cnt  <= '0;
                trig_cnt  <= '0;
                trig_seen <= 1'b0;
                armed     <= 1'b0;
            end else if (state_nxt == RUN) begin
                smpl_cnt  <= smpl_nxt;
                trig_cnt  <= trig_cnt_nxt;
                trig_seen <= eff_trig;
                armed     <= arm_nxt;
            end else begin
                trig_seen <= 1'b0;
                armed     <= 1'b0;
            end
            // The next write slot is the oldest sample once the buffer is full.
            if (done) ram_addr <= waddr_nxt;
        end
    end

endmodule

// File: tb/tb_capture_wrt.sv
// Bench for capture_wrt: a write-count/modulo-address model checked every cycle,
// directed capture scenarios with literal expectations, then randomized captures.
module tb_capture_wrt;
    import capture_pkg::*;

    localparam int E = DEF_ENTRIES;
    localparam int L = DEF_LOG2;

    logic         clk = 1'b0;
    logic         rst, start, abort, wrt_smpl, triggered;
    logic [L-1:0] trig_pos;
    logic         we, armed, capturing, set_capture_done;
    logic [L-1:0] waddr, ram_addr;

    always #5 clk = ~clk;

    capture_wrt #(.ENTRIES(E), .LOG2(L)) dut (
        .clk              (clk),
        .rst              (rst),
        .start            (start),
        .abort            (abort),
        .wrt_smpl         (wrt_smpl),
        .triggered        (triggered),
        .trig_pos         (trig_pos),
        .we               (we),
        .waddr            (waddr),
        .armed            (armed),
        .capturing        (capturing),
        .set_capture_done (set_capture_done),
        .ram_addr         (ram_addr)
    );

    int vectors = 0, miscompares = 0;
    // model: mode 0 idle / 1 capturing / 2 finished; nw = writes this capture
    int md = 0, nw = 0, addr = 0, post = 0, ram = 0;
    bit acc = 0, marm = 0, mdone = 0;
    // observations of DUT activity
    int cnt_we = 0, cnt_done = 0, arm_at = 0, done_ram = 0;
    bit prev_armed = 0;

    task automatic chk(input string n, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d at t=%0t", n, act, exp, $time);
        end
    endtask

    // Compare DUT against model at negedge, then advance model over the coming edge.
    task automatic tick();
        int tpv;
        bit acc_now, exp_we;
        @(negedge clk);
        tpv = (int'(trig_pos) >= E) ? E - 1 : int'(trig_pos);
        if (rst) begin
            md = 0; nw = 0; addr = 0; post = 0; ram = 0;
            acc = 0; marm = 0; mdone = 0;
        end
        acc_now = (md == 1) && (acc || (triggered && marm));
        exp_we  = (md == 1) && wrt_smpl && !(acc_now && post == tpv);
        chk("we",        int'(we),               int'(exp_we));
        chk("waddr",     int'(waddr),            addr);
        chk("armed",     int'(armed),            int'(marm));
        chk("capturing", int'(capturing),        int'(md == 1));
        chk("done",      int'(set_capture_done), int'(mdone));
        chk("ram_addr",  int'(ram_addr),         ram);
        if (armed && !prev_armed) arm_at = cnt_we;
        prev_armed = armed;
        if (we) cnt_we++;
        if (set_capture_done) begin cnt_done++; done_ram = int'(ram_addr); end
        if (!rst) begin
            mdone = 0;
            if (abort) begin
                if (exp_we) addr = (addr + 1) % E;
                md = 0; acc = 0; marm = 0;
            end else if (start && md != 1) begin
                md = 1; nw = 0; addr = 0; post = 0; acc = 0; marm = 0;
            end else if (md == 1) begin
                if (exp_we) begin
                    addr = (addr + 1) % E;
                    nw++;
                    if (acc_now) post++;
                end
                if (acc_now && post == tpv) begin
                    md = 2; mdone = 1; ram = addr; acc = 0; marm = 0;
                end else begin
                    acc  = acc_now;
                    marm = (((nw < E) ? nw : E) + tpv) >= E;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        start = 0; abort = 0; wrt_smpl = 0; triggered = 0;
    endtask

    // One capture from start to done; trigger is a level from write trig_after on,
    // or a single pulse at that write count. start_again re-pulses start mid-run.
    task automatic capture(input int tpv, input int period, input int trig_after, input bit pulse,
                           input int start_again, output int writes, output int armw);
        int base, d0, k;
        bit pulsed, restarted;
        base = cnt_we; d0 = cnt_done; pulsed = 0; restarted = 0;
        trig_pos = L'(tpv);
        quiet(); start = 1; tick(); start = 0;
        k = 0;
        while (cnt_done == d0 && k < 5000) begin
            wrt_smpl = (k % period) == 0;
            if (pulse) begin
                triggered = !pulsed && (cnt_we - base) == trig_after;
                if (triggered) pulsed = 1;
            end else begin
                triggered = (cnt_we - base) >= trig_after;
            end
            start = !restarted && start_again >= 0 && (cnt_we - base) == start_again;
            if (start) restarted = 1;
            tick();
            k++;
        end
        quiet();
        repeat (3) tick();
        chk("done_pulses", cnt_done - d0, 1);
        writes = cnt_we - base;
        armw   = arm_at - base;
    endtask

    initial begin
        int w, a, base, d0, k;
        rst = 1; quiet(); trig_pos = '0;
        repeat (3) tick();
        rst = 0;
        repeat (2) tick();
        wrt_smpl = 1; triggered = 1;
        repeat (4) tick();
        chk("idle_writes", cnt_we, 0);
        quiet();

        capture(100, 1, 50, 0, 100, w, a);
        chk("s1_writes", w, 384);
        chk("s1_arm_after", a, 284);
        chk("s1_ram_addr", done_ram, 0);
        chk("s1_waddr", int'(waddr), 0);

        capture(0, 1, 0, 0, -1, w, a);
        chk("s2_writes", w, 384);
        chk("s2_arm_after", a, 384);
        chk("s2_ram_addr", done_ram, 0);

        capture(10, 1, 500, 1, -1, w, a);
        chk("s3_writes", w, 510);
        chk("s3_arm_after", a, 374);
        chk("s3_ram_addr", done_ram, 126);

        wrt_smpl = 1; tick(); tick();
        start = 1; tick(); start = 0;
        chk("restart_waddr", int'(waddr), 0);
        chk("restart_capturing", int'(capturing), 1);
        wrt_smpl = 1; repeat (5) tick();
        abort = 1; tick(); abort = 0; wrt_smpl = 0;
        chk("abort_capturing", int'(capturing), 0);

        capture(400, 4, 0, 0, -1, w, a);
        chk("s4_writes", w, 384);
        chk("s4_arm_after", a, 1);
        chk("s4_ram_addr", done_ram, 0);

        // abort part-way through, then abort+start together
        base = cnt_we; d0 = cnt_done; trig_pos = L'(50);
        start = 1; tick(); start = 0;
        wrt_smpl = 1; triggered = 1; k = 0;
        while ((cnt_we - base) < 200 && k < 1000) begin tick(); k++; end
        chk("abort_at_write", cnt_we - base, 200);
        abort = 1; tick(); abort = 0;
        chk("abort_idle", int'(capturing), 0);
        repeat (5) tick();
        chk("abort_no_done", cnt_done - d0, 0);
        start = 1; tick(); start = 0;
        repeat (10) tick();
        start = 1; abort = 1; tick(); start = 0; abort = 0;
        chk("abort_start_idle", int'(capturing), 0);
        quiet();

        // reset in the middle of a capture
        start = 1; tick(); start = 0;
        wrt_smpl = 1; repeat (50) tick();
        rst = 1; tick();
        chk("rst_we", int'(we), 0);
        chk("rst_waddr", int'(waddr), 0);
        chk("rst_capturing", int'(capturing), 0);
        rst = 0; quiet(); repeat (2) tick();

        // randomized captures
        for (int c = 0; c < 8; c++) begin
            int period;
            period   = int'($urandom_range(1, 3));
            trig_pos = L'($urandom_range(0, 2**L - 1));
            start = 1; tick(); start = 0;
            d0 = cnt_done;
            for (int j = 0; j < 3000 && cnt_done == d0; j++) begin
                wrt_smpl  = ($urandom_range(0, period - 1) == 0);
                triggered = ($urandom_range(0, 7) == 0);
                start     = ($urandom_range(0, 499) == 0);
                abort     = ($urandom_range(0, 2999) == 0);
                tick();
            end
            quiet();
            repeat (3) tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/capture_wrt.md
# capture_wrt

Capture-side writer for the per-channel RAMqueue sample buffers: the write-address generator and capture controller whose results the command processor later reads out in a dump. The block writes decimated samples circularly into an ENTRIES-deep queue and arms once enough pre-trigger history exists. After a trigger it keeps exactly trig_pos more samples, then pulses set_capture_done and presents the oldest-sample address on ram_addr for the dump.

## Interface
- ENTRIES, 384, queue depth in samples
- LOG2, 9, address width; ENTRIES <= 2**LOG2
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  one-cycle pulse, begin a capture
- abort  in  1  one-cycle pulse, cancel and return to IDLE
- wrt_smpl  in  1  decimated sample-valid strobe
- triggered  in  1  trigger event from trigger logic (level, sampled every cycle)
- trig_pos  in  LOG2  post-trigger sample count; values >= ENTRIES clamp to ENTRIES-1
- we  out  1  RAMqueue write enable (shared by all channel queues)
- waddr  out  LOG2  RAMqueue write address
- armed  out  1  pre-trigger history satisfied, trigger may be accepted
- capturing  out  1  high while in RUN
- set_capture_done  out  1  one-cycle pulse on capture completion
- ram_addr  out  LOG2  oldest valid sample address, valid in DONE

## Operation
- States: IDLE, RUN, DONE. Reset -> IDLE, all outputs and counters 0.
- IDLE: no writes. start -> RUN, waddr=0, smpl_cnt=0, trig_cnt=0, trig_seen=0, armed=0.
- RUN:
  - we = wrt_smpl & !(eff_trig & trig_cnt == tp), with eff_trig = trig_seen | (triggered & armed) and tp = clamped trig_pos.
  - On each we, waddr increments, wrapping ENTRIES-1 -> 0.
  - smpl_cnt counts writes, saturating at ENTRIES.
  - armed <= (smpl_cnt + tp >= ENTRIES), computed in LOG2+1 bits, using the post-update smpl_cnt.
  - triggered while !armed is ignored, not latched. Once accepted, trig_seen holds until the state leaves RUN.
  - After acceptance, every we increments trig_cnt; a write in the accept cycle counts as post-trigger sample 1.
  - When eff_trig and the next trig_cnt == tp: go to DONE, set_capture_done=1 for one cycle, ram_addr <= next waddr.
  - tp=0: DONE in the accept cycle with no write in that cycle.
- DONE: we=0, ram_addr and waddr held, armed=0. start -> restart as from IDLE; abort -> IDLE.
- Priority: abort > start > all else. start in RUN is ignored. abort with start -> IDLE.
- Buffer is always full at DONE (smpl_cnt + tp >= ENTRIES), so the next write address is the oldest sample.

## Timing
- we is combinational from registered state/counters and wrt_smpl; RAMqueue writes at the current waddr on that edge.
- waddr, armed, state, ram_addr and set_capture_done are registered.
- armed rises the cycle after the write that satisfies the condition.
- set_capture_done and ram_addr update on the same edge that enters DONE.
- Reset mid-capture: immediate return to IDLE, no done pulse, we=0 asynchronously.

## Structure
- Shared package capture_pkg: typedef enum cap_state_t {IDLE, RUN, DONE}; ENTRIES/LOG2 default constants, shared with cmd_cfg and RAMqueue.
- One natural sub-module: wrap_cnt, a LOG2-bit modulo-ENTRIES incrementing counter with enable and clear, used for waddr.
- Everything else lives in the top module.

## Test plan
- Reset and idle: assert rst mid-stream -> we, armed, capturing, set_capture_done, waddr, ram_addr all 0; wrt_smpl in IDLE -> no we.
- Arming: trig_pos=100, start, wrt_smpl every cycle, triggered held high from write 50 -> armed rises after write 284; trigger is accepted then. Exactly 100 post-trigger writes (384 total), one set_capture_done pulse, ram_addr=0, waddr=0.
- Zero post-trigger: trig_pos=0 -> armed after 384 writes; trigger accepted with no write that cycle; DONE; ram_addr=0.
- Wrap-around: trig_pos=10, triggered pulsed after write 500 -> 510 total writes, waddr wraps 383->0, ram_addr=126.
- Decimation and clamp: wrt_smpl every 4th cycle, trig_pos=400 (clamped to 383) -> armed after write 1; trigger accepted; 383 post-trigger writes, one per strobe; done pulse once.
- Control: abort at write 200 -> IDLE next cycle, no done pulse; start during RUN ignored; abort+start together -> IDLE; start in DONE -> fresh capture with waddr=0.
